// File: rtl/count_evt_pkg.sv
// Shared types for the counter event tracker: event kinds, tracker states and
// the event record layout at the default counter width.
package count_evt_pkg;

  localparam int EVT_W = 8;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    WRAP = 2'd2,
    JUMP = 2'd3
  } evt_kind_t;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } trk_state_t;

  typedef struct packed {
    evt_kind_t        kind;
    logic [EVT_W-1:0] prev;
    logic [EVT_W-1:0] cur;
  } evt_rec_t;

endpackage

// File: rtl/count_evt_fifo.sv
// Synchronous FIFO for event records; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module count_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/count_event_tracker.sv
// Observes a free-running counter, classifies each sampled transition and
// queues WRAP/JUMP records for a valid/ready consumer.
module count_event_tracker
  import count_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_kind,
  output logic [WIDTH-1:0] evt_prev,
  output logic [WIDTH-1:0] evt_cur,
  output logic [WRAPW-1:0] wrap_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int RW = 2 + 2 * WIDTH;

  trk_state_t       state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WRAPW-1:0] wrap_q;
  logic             ovf_q;

  evt_kind_t        kind_d;
  logic [WIDTH-1:0] prev_inc;
  logic             active;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [RW-1:0]    head;

  assign prev_inc = prev_q + WIDTH'(1);

  // WRAP is tested before STEP since 0xFF -> 0x00 also satisfies the modulo increment.
  always_comb begin
    kind_d = JUMP;
    if (value == prev_q)                         kind_d = HOLD;
    else if ((prev_q == '1) && (value == '0))    kind_d = WRAP;
    else if (value == prev_inc)                  kind_d = STEP;
  end

  assign active = (state_q == TRACK) && enable;
  assign push   = active && ((kind_d == WRAP) || (kind_d == JUMP));
  assign pop    = !empty && evt_ready;
  assign drop   = push && full && !pop;

  count_evt_fifo #(
    .DEPTH (DEPTH),
    .DW    (RW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({kind_d, prev_q, value}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      wrap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            prev_q  <= value;
            state_q <= TRACK;
          end
        end
        TRACK: begin
          if (!enable) state_q <= IDLE;
          else         prev_q  <= value;
        end
        default: state_q <= IDLE;
      endcase
      if (active && (kind_d == WRAP) && (wrap_q != '1)) begin
        wrap_q <= wrap_q + WRAPW'(1);
      end
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign evt_valid  = !empty;
  assign evt_kind   = empty ? 2'd0 : head[RW-1 -: 2];
  assign evt_prev   = empty ? '0 : head[2*WIDTH-1 -: WIDTH];
  assign evt_cur    = empty ? '0 : head[WIDTH-1:0];
  assign wrap_count = wrap_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_count_event_tracker.sv
// Directed bench for count_event_tracker with hand-computed expected records.
module tb_count_event_tracker;
  import count_evt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] value = 8'h00;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [1:0] evt_kind;
  logic [7:0] evt_prev;
  logic [7:0] evt_cur;
  logic [7:0] wrap_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int total = 0;
  int bad   = 0;
  evt_rec_t got_q [$];
  evt_rec_t exp_r;

  count_event_tracker #(.WIDTH(8), .DEPTH(4), .WRAPW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value      (value),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_kind   (evt_kind),
    .evt_prev   (evt_prev),
    .evt_cur    (evt_cur),
    .wrap_count (wrap_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic evt_rec_t rec(input evt_kind_t k, input logic [7:0] p, input logic [7:0] c);
    evt_rec_t r;
    r.kind = k;
    r.prev = p;
    r.cur  = c;
    return r;
  endfunction

  function automatic logic [31:0] head_now();
    return {14'd0, evt_kind, evt_prev, evt_cur};
  endfunction

  // Records that will be popped on the coming edge are captured just before it.
  task automatic step(input logic [7:0] v);
    evt_rec_t r;
    if (evt_valid && evt_ready) begin
      r.kind = evt_kind_t'(evt_kind);
      r.prev = evt_prev;
      r.cur  = evt_cur;
      got_q.push_back(r);
    end
    value = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_wrap",  {24'd0, wrap_count}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    chk("rst_head",  head_now(), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // free-running count through wrap
    step(8'hFC);
    step(8'hFD);
    step(8'hFE);
    step(8'hFF);
    chk("wrap_pre_valid", {31'd0, evt_valid}, 32'd0);
    step(8'h00);
    chk("wrap_lat_valid", {31'd0, evt_valid}, 32'd1);
    step(8'h01);
    step(8'h02);
    step(8'h03);
    chk("wrap_nrec", got_q.size(), 32'd1);
    exp_r = rec(WRAP, 8'hFF, 8'h00);
    if (got_q.size() > 0) chk("wrap_rec", {14'd0, got_q[0]}, {14'd0, exp_r});
    chk("wrap_count1", {24'd0, wrap_count}, 32'd1);

    // forced zero mid-count
    got_q.delete();
    enable = 1'b0;
    step(8'h03);
    enable = 1'b1;
    step(8'h41);
    step(8'h42);
    step(8'h00);
    step(8'h00);
    step(8'h01);
    step(8'h02);
    chk("fz_nrec", got_q.size(), 32'd1);
    exp_r = rec(JUMP, 8'h42, 8'h00);
    if (got_q.size() > 0) chk("fz_rec", {14'd0, got_q[0]}, {14'd0, exp_r});

    // backpressure, overflow with clr_ovf on the same edge (set wins)
    evt_ready = 1'b0;
    step(8'h10);
    step(8'h20);
    step(8'h30);
    step(8'h40);
    chk("bp_ovf_at4", {31'd0, overflow}, 32'd0);
    exp_r = rec(JUMP, 8'h02, 8'h10);
    chk("bp_head4", head_now(), {14'd0, exp_r});
    clr_ovf = 1'b1;
    step(8'h50);
    clr_ovf = 1'b0;
    chk("bp_ovf_set", {31'd0, overflow}, 32'd1);
    chk("bp_head5", head_now(), {14'd0, exp_r});
    got_q.delete();
    evt_ready = 1'b1;
    repeat (5) step(8'h50);
    chk("bp_nrec", got_q.size(), 32'd4);
    if (got_q.size() == 4) begin
      exp_r = rec(JUMP, 8'h02, 8'h10); chk("bp_rec0", {14'd0, got_q[0]}, {14'd0, exp_r});
      exp_r = rec(JUMP, 8'h10, 8'h20); chk("bp_rec1", {14'd0, got_q[1]}, {14'd0, exp_r});
      exp_r = rec(JUMP, 8'h20, 8'h30); chk("bp_rec2", {14'd0, got_q[2]}, {14'd0, exp_r});
      exp_r = rec(JUMP, 8'h30, 8'h40); chk("bp_rec3", {14'd0, got_q[3]}, {14'd0, exp_r});
    end
    chk("bp_empty", {31'd0, evt_valid}, 32'd0);
    chk("bp_ovf_hold", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    step(8'h50);
    clr_ovf = 1'b0;
    chk("bp_ovf_clr", {31'd0, overflow}, 32'd0);

    // full FIFO with simultaneous push and pop
    evt_ready = 1'b0;
    step(8'h60);
    step(8'h70);
    step(8'h80);
    step(8'h90);
    got_q.delete();
    evt_ready = 1'b1;
    step(8'hA0);
    chk("fpp_ovf", {31'd0, overflow}, 32'd0);
    repeat (6) step(8'hA0);
    chk("fpp_nrec", got_q.size(), 32'd5);
    if (got_q.size() == 5) begin
      exp_r = rec(JUMP, 8'h50, 8'h60); chk("fpp_rec0", {14'd0, got_q[0]}, {14'd0, exp_r});
      exp_r = rec(JUMP, 8'h90, 8'hA0); chk("fpp_rec4", {14'd0, got_q[4]}, {14'd0, exp_r});
    end

    // enable gap
    step(8'h10);
    step(8'h10);
    step(8'h10);
    got_q.delete();
    enable = 1'b0;
    step(8'h10);
    step(8'h80);
    step(8'h80);
    enable = 1'b1;
    step(8'h80);
    step(8'h81);
    step(8'h81);
    step(8'h81);
    chk("gap_nrec", got_q.size(), 32'd0);
    chk("gap_valid", {31'd0, evt_valid}, 32'd0);
    chk("gap_wrap", {24'd0, wrap_count}, 32'd1);

    // reset mid-operation
    step(8'hFF);
    step(8'h00);
    step(8'hFF);
    step(8'h00);
    step(8'h05);
    evt_ready = 1'b0;
    step(8'h07);
    chk("pre_rst_wrap", {24'd0, wrap_count}, 32'd3);
    chk("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, evt_valid}, 32'd0);
    chk("arst_wrap", {24'd0, wrap_count}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    evt_ready = 1'b1;
    got_q.delete();
    step(8'h20);
    chk("post_rst_arm", {31'd0, evt_valid}, 32'd0);
    step(8'h30);
    exp_r = rec(JUMP, 8'h20, 8'h30);
    chk("post_rst_valid", {31'd0, evt_valid}, 32'd1);
    chk("post_rst_head", head_now(), {14'd0, exp_r});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
